fp_sgnj_issue: RTL and testbench

- Issue/operand stage directly upstream of the FP sign-injection units (FSGNJ/FSGNJN/FSGNJX), for both S and D formats.
- Accepts decoded sign-injection ops with register-file operand values.
- Performs RISC-V NaN-unboxing of single-precision operands held in 64-bit FP registers.
- Buffers ops in a 2-entry queue with valid/ready handshakes on both sides; drives the combinational sign-injection datapath with registered operands.

---
 rtl/fp_sgnj_issue.sv | 116 +++++++++++
 tb/tb_fp_sgnj_issue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sgnj_issue.sv
// Issue stage for FSGNJ/FSGNJN/FSGNJX: decodes funct3, NaN-unboxes S operands, 2-entry queue.
// Optional FPU_NANBOX_CHECK_EN enables the upper-half NaN-box check with canonical-NaN substitution.
module fp_sgnj_issue #(
  parameter int unsigned BUS_WIDTH = 64,
  parameter int unsigned TAG_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_funct3,
  input  logic                 in_fmt,
  input  logic [BUS_WIDTH-1:0] in_rs1,
  input  logic [BUS_WIDTH-1:0] in_rs2,
  input  logic [TAG_W-1:0]     in_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_op,
  output logic                 out_fmt,
  output logic [BUS_WIDTH-1:0] out_in1,
  output logic [BUS_WIDTH-1:0] out_in2,
  output logic [TAG_W-1:0]     out_rd,
  output logic                 out_illegal
);

  typedef struct packed {
    logic [1:0]           op;
    logic                 fmt;
    logic [BUS_WIDTH-1:0] in1;
    logic [BUS_WIDTH-1:0] in2;
    logic [TAG_W-1:0]     rd;
    logic                 illegal;
  } entry_t;

  entry_t     mem_q [2];
  entry_t     new_entry;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  // Single-precision operand as held in a 64-bit FP register.
  function automatic logic [BUS_WIDTH-1:0] prep_s(input logic [BUS_WIDTH-1:0] x);
    logic [BUS_WIDTH-1:0] r;
    r = '0;
`ifdef FPU_NANBOX_CHECK_EN
    r[31:0] = (x[63:32] == 32'hFFFF_FFFF) ? x[31:0] : 32'h7fc0_0000;
`else
    r[31:0] = x[31:0];
`endif
    return r;
  endfunction

  always_comb begin
    new_entry         = '0;
    new_entry.fmt     = in_fmt;
    new_entry.rd      = in_rd;
    if (in_funct3 == 3'b000 || in_funct3 == 3'b001 || in_funct3 == 3'b010) begin
      new_entry.op  = in_funct3[1:0];
      new_entry.in1 = in_fmt ? in_rs1 : prep_s(in_rs1);
      new_entry.in2 = in_fmt ? in_rs2 : prep_s(in_rs2);
    end else begin
      // Reserved encodings still travel down the pipe so the trap is raised in order.
      new_entry.op      = 2'd3;
      new_entry.illegal = 1'b1;
    end
  end

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push && !flush) mem_q[wr_ptr_q] <= new_entry;
    end
  end

  assign out_op      = mem_q[rd_ptr_q].op;
  assign out_fmt     = mem_q[rd_ptr_q].fmt;
  assign out_in1     = mem_q[rd_ptr_q].in1;
  assign out_in2     = mem_q[rd_ptr_q].in2;
  assign out_rd      = mem_q[rd_ptr_q].rd;
  assign out_illegal = mem_q[rd_ptr_q].illegal;

endmodule

// File: tb/tb_fp_sgnj_issue.sv
// Scoreboard bench for fp_sgnj_issue: directed ops push expectations, a negedge monitor checks pops.
module tb_fp_sgnj_issue;

  typedef struct packed {
    logic [1:0]  op;
    logic        fmt;
    logic [63:0] in1;
    logic [63:0] in2;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_fmt, out_valid, out_ready;
  logic        out_fmt, out_illegal;
  logic [2:0]  in_funct3;
  logic [63:0] in_rs1, in_rs2, out_in1, out_in2;
  logic [4:0]  in_rd, out_rd;
  logic [1:0]  out_op;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t prev;
  logic prev_hold = 1'b0;

  always #5 clk = ~clk;

  fp_sgnj_issue #(.BUS_WIDTH(64), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_fmt(in_fmt), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_fmt(out_fmt),
    .out_in1(out_in1), .out_in2(out_in2), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  function automatic exp_t mk(input logic [1:0] op, input logic fmt, input logic [63:0] a,
                              input logic [63:0] b, input logic [4:0] rd, input logic ill);
    exp_t e;
    e.op = op; e.fmt = fmt; e.in1 = a; e.in2 = b; e.rd = rd; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " out_op"}, 64'(out_op), 64'd0);
    chk({tag, " out_fmt"}, 64'(out_fmt), 64'd0);
    chk({tag, " out_in1"}, out_in1, 64'd0);
    chk({tag, " out_in2"}, out_in2, 64'd0);
    chk({tag, " out_rd"}, 64'(out_rd), 64'd0);
    chk({tag, " out_illegal"}, 64'(out_illegal), 64'd0);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Holds in_valid high until accepted; the caller deasserts it (allows back-to-back pushes).
  task automatic send(input logic [2:0] f3, input logic fmt, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] rd, input exp_t e,
                      output int waits);
    in_valid = 1'b1; in_funct3 = f3; in_fmt = fmt; in_rs1 = a; in_rs2 = b; in_rd = rd;
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 50) begin
        chk("accept timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        return;
      end
    end
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain scoreboard empty", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    act = mk(out_op, out_fmt, out_in1, out_in2, out_rd, out_illegal);
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && out_valid) begin
        checks++;
        if (act !== prev) begin
          errors++;
          $display("FAIL stall stability: got %h held %h", act, prev);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected output: got %h expected none", act);
        end else begin
          e = sb.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL output rd=%0d: got %h expected %h", e.rd, act, e);
          end
        end
      end
      prev_hold = out_valid && !out_ready;
      prev = act;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    logic [63:0] s_exp2;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct3 = 3'b000; in_fmt = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("post-reset");

    // D-format FSGNJN, passes operands through untouched.
    out_ready = 1'b1;
    send(3'b001, 1'b1, 64'h3FF0000000000000, 64'h4000000000000000, 5'd1,
         mk(2'd1, 1'b1, 64'h3FF0000000000000, 64'h4000000000000000, 5'd1, 1'b0), w);
    chk("latency out_valid", 64'(out_valid), 64'd1);
    chk("latency out_op", 64'(out_op), 64'd1);
`ifdef FPU_NANBOX_CHECK_EN
    s_exp2 = 64'h000000007fc00000;
`else
    s_exp2 = 64'h00000000C0000000;
`endif
    send(3'b000, 1'b0, 64'hFFFFFFFF3F800000, 64'h00000000C0000000, 5'd2,
         mk(2'd0, 1'b0, 64'h000000003F800000, s_exp2, 5'd2, 1'b0), w);
    send(3'b010, 1'b0, 64'hFFFFFFFF40490FDB, 64'hFFFFFFFFBF800000, 5'd3,
         mk(2'd2, 1'b0, 64'h0000000040490FDB, 64'h00000000BF800000, 5'd3, 1'b0), w);
    idle(3);
    drain();

    // Backpressure: two fill the buffer, the third waits for the first pop.
    out_ready = 1'b0;
    send(3'b000, 1'b1, 64'h1, 64'h2, 5'd10, mk(2'd0, 1'b1, 64'h1, 64'h2, 5'd10, 1'b0), w);
    send(3'b001, 1'b1, 64'h3, 64'h4, 5'd11, mk(2'd1, 1'b1, 64'h3, 64'h4, 5'd11, 1'b0), w);
    in_funct3 = 3'b010; in_fmt = 1'b1; in_rs1 = 64'h5; in_rs2 = 64'h6; in_rd = 5'd12;
    @(negedge clk);
    chk("full in_ready", 64'(in_ready), 64'd0);
    idle(2);
    in_valid = 1'b1;
    chk("still full in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    send(3'b010, 1'b1, 64'h5, 64'h6, 5'd12, mk(2'd2, 1'b1, 64'h5, 64'h6, 5'd12, 1'b0), w);
    chk("third accept wait cycles", 64'(w), 64'd1);
    idle(1);
    drain();

    // Concurrent push/pop at count 1: in_ready must never drop.
    for (int i = 0; i < 10; i++) begin
      send(3'b001, 1'b1, 64'(i) << 8, ~(64'(i)), 5'(16 + i),
           mk(2'd1, 1'b1, 64'(i) << 8, ~(64'(i)), 5'(16 + i), 1'b0), w);
      chk("stream no stall", 64'(w), 64'd0);
    end
    idle(1);
    drain();

    send(3'b101, 1'b1, 64'hDEAD, 64'hBEEF, 5'd20, mk(2'd3, 1'b1, 64'd0, 64'd0, 5'd20, 1'b1), w);
    send(3'b010, 1'b1, 64'hDEAD, 64'hBEEF, 5'd21,
         mk(2'd2, 1'b1, 64'hDEAD, 64'hBEEF, 5'd21, 1'b0), w);
    idle(1);
    drain();

    // Flush with a full buffer and a concurrent push.
    out_ready = 1'b0;
    send(3'b000, 1'b1, 64'h7, 64'h8, 5'd25, mk(2'd0, 1'b1, 64'h7, 64'h8, 5'd25, 1'b0), w);
    send(3'b000, 1'b1, 64'h9, 64'hA, 5'd26, mk(2'd0, 1'b1, 64'h9, 64'hA, 5'd26, 1'b0), w);
    in_rd = 5'd27;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    idle(4);
    send(3'b001, 1'b1, 64'hB, 64'hC, 5'd28, mk(2'd1, 1'b1, 64'hB, 64'hC, 5'd28, 1'b0), w);
    idle(1);
    drain();

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    send(3'b000, 1'b1, 64'hD, 64'hE, 5'd29, mk(2'd0, 1'b1, 64'hD, 64'hE, 5'd29, 1'b0), w);
    send(3'b000, 1'b1, 64'hF, 64'h10, 5'd30, mk(2'd0, 1'b1, 64'hF, 64'h10, 5'd30, 1'b0), w);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid reset");
    sb.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    out_ready = 1'b1;
    idle(4);
    chk("after reset out_valid", 64'(out_valid), 64'd0);
    send(3'b010, 1'b0, 64'hFFFFFFFF00000001, 64'hFFFFFFFF80000000, 5'd31,
         mk(2'd2, 1'b0, 64'h0000000000000001, 64'h0000000080000000, 5'd31, 1'b0), w);
    idle(1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
